// File: rtl/tgt_hdr_ddr_rx.sv
// Target-side HDR-DDR receiver: samples SDA on both SCL edges, frames 20-bit
// words, checks preamble/parity, decodes commands and spots Restart/Exit.
module tgt_hdr_ddr_rx (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst_n,
    input  logic        i_hdr_en,
    input  logic        i_scl,
    input  logic        i_sda,
    input  logic [6:0]  i_dyn_addr,
    input  logic        i_rd_done,
    output logic        o_cmd_valid,
    output logic        o_cmd_rnw,
    output logic [6:0]  o_cmd_code,
    output logic        o_data_valid,
    output logic [15:0] o_data,
    output logic        o_crc_valid,
    output logic [4:0]  o_crc,
    output logic        o_rd_req,
    output logic        o_parity_err,
    output logic        o_frame_err,
    output logic        o_restart,
    output logic        o_exit
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_IGNORE  = 3'd3;
    localparam logic [2:0] ST_RD_WAIT = 3'd4;
    localparam logic [2:0] ST_ERR     = 3'd5;

    logic [2:0]  state_q, state_d;
    logic        scl_q, sda_q, hdr_en_q;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [18:0] shreg_q, shreg_d;
    logic [2:0]  fall_cnt_q, fall_cnt_d;

    logic        cmd_valid_q, cmd_valid_d;
    logic        cmd_rnw_q, cmd_rnw_d;
    logic [6:0]  cmd_code_q, cmd_code_d;
    logic        data_valid_q, data_valid_d;
    logic [15:0] data_q, data_d;
    logic        crc_valid_q, crc_valid_d;
    logic [4:0]  crc_q, crc_d;
    logic        rd_req_q, rd_req_d;
    logic        parity_err_q, parity_err_d;
    logic        frame_err_q, frame_err_d;
    logic        restart_q, restart_d;
    logic        exit_q, exit_d;

    logic        scl_edge, scl_rise, sda_fall_low, active;
    logic        exit_det, restart_det;
    logic [19:0] word;
    logic [1:0]  pre;
    logic [15:0] dat;
    logic [1:0]  par;
    logic        par_ok, addr_hit;

    assign scl_edge     = i_scl ^ scl_q;
    assign scl_rise     = i_scl & ~scl_q;
    assign sda_fall_low = sda_q & ~i_sda & ~scl_q & ~i_scl;
    assign active       = (state_q != ST_IDLE);

    assign exit_det    = active && sda_fall_low && (fall_cnt_q == 3'd3);
    assign restart_det = active && scl_rise && (fall_cnt_q == 3'd2);

    // First bit on the wire ends up in word[19].
    assign word = {shreg_q, i_sda};
    assign pre  = word[19:18];
    assign dat  = word[17:2];
    assign par  = word[1:0];

    assign par_ok = (par[1] == ^(dat & 16'hAAAA)) &&
                    (par[0] == ~^(dat & 16'h5555));
    assign addr_hit = (dat[7:1] == i_dyn_addr) || (dat[7:1] == 7'h7E);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        fall_cnt_d   = fall_cnt_q;
        cmd_valid_d  = 1'b0;
        cmd_rnw_d    = cmd_rnw_q;
        cmd_code_d   = cmd_code_q;
        data_valid_d = 1'b0;
        data_d       = data_q;
        crc_valid_d  = 1'b0;
        crc_d        = crc_q;
        rd_req_d     = rd_req_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        restart_d    = 1'b0;
        exit_d       = 1'b0;

        if (!i_hdr_en) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            fall_cnt_d = '0;
            rd_req_d   = 1'b0;
        end else if (!active) begin
            fall_cnt_d = '0;
            if (!hdr_en_q) begin
                state_d   = ST_CMD;
                bit_cnt_d = '0;
            end
        end else begin
            if (scl_rise) begin
                fall_cnt_d = '0;
            end else if (sda_fall_low && fall_cnt_q != 3'd4) begin
                fall_cnt_d = fall_cnt_q + 3'd1;
            end

            if (exit_det) begin
                exit_d     = 1'b1;
                state_d    = ST_IDLE;
                rd_req_d   = 1'b0;
                bit_cnt_d  = '0;
                fall_cnt_d = '0;
            end else if (restart_det) begin
                // The restart SCL rise is framing, never a data bit.
                restart_d = 1'b1;
                state_d   = ST_CMD;
                bit_cnt_d = '0;
                rd_req_d  = 1'b0;
            end else if (state_q == ST_RD_WAIT) begin
                if (i_rd_done) begin
                    rd_req_d = 1'b0;
                    state_d  = ST_CMD;
                end
            end else if (scl_edge) begin
                shreg_d = word[18:0];
                if (bit_cnt_q != 5'd19) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end else begin
                    bit_cnt_d = '0;
                    unique case (state_q)
                        ST_CMD: begin
                            if (pre != 2'b01) begin
                                frame_err_d = 1'b1;
                                state_d     = ST_ERR;
                            end else if (!par_ok) begin
                                parity_err_d = 1'b1;
                                state_d      = ST_ERR;
                            end else if (addr_hit) begin
                                cmd_valid_d = 1'b1;
                                cmd_rnw_d   = dat[15];
                                cmd_code_d  = dat[14:8];
                                if (dat[15]) begin
                                    rd_req_d = 1'b1;
                                    state_d  = ST_RD_WAIT;
                                end else begin
                                    state_d = ST_DATA;
                                end
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                        ST_DATA: begin
                            if (pre == 2'b10) begin
                                if (par_ok) begin
                                    data_valid_d = 1'b1;
                                    data_d       = dat;
                                end else begin
                                    parity_err_d = 1'b1;
                                    state_d      = ST_ERR;
                                end
                            end else if (pre == 2'b01 && dat[15:12] == 4'hC) begin
                                crc_valid_d = 1'b1;
                                crc_d       = dat[11:7];
                                state_d     = ST_CMD;
                            end else begin
                                frame_err_d = 1'b1;
                                state_d     = ST_ERR;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q      <= ST_IDLE;
            scl_q        <= 1'b0;
            sda_q        <= 1'b0;
            hdr_en_q     <= 1'b0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            fall_cnt_q   <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_rnw_q    <= 1'b0;
            cmd_code_q   <= '0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
            crc_valid_q  <= 1'b0;
            crc_q        <= '0;
            rd_req_q     <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            restart_q    <= 1'b0;
            exit_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            scl_q        <= i_scl;
            sda_q        <= i_sda;
            hdr_en_q     <= i_hdr_en;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            fall_cnt_q   <= fall_cnt_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_rnw_q    <= cmd_rnw_d;
            cmd_code_q   <= cmd_code_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            crc_valid_q  <= crc_valid_d;
            crc_q        <= crc_d;
            rd_req_q     <= rd_req_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            restart_q    <= restart_d;
            exit_q       <= exit_d;
        end
    end

    assign o_cmd_valid  = cmd_valid_q;
    assign o_cmd_rnw    = cmd_rnw_q;
    assign o_cmd_code   = cmd_code_q;
    assign o_data_valid = data_valid_q;
    assign o_data       = data_q;
    assign o_crc_valid  = crc_valid_q;
    assign o_crc        = crc_q;
    assign o_rd_req     = rd_req_q;
    assign o_parity_err = parity_err_q;
    assign o_frame_err  = frame_err_q;
    assign o_restart    = restart_q;
    assign o_exit       = exit_q;

endmodule
